median_scan_ctrl: RTL and testbench

// Frame sequencer for the median-filter datapath. On start, raster-scans a

---
 rtl/median_scan_ctrl.sv | 176 +++++++++++++++++
 tb/tb_median_scan_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/median_scan_ctrl.sv
// Frame sequencer for the median-filter datapath: raster-scans a rows x cols
// image, hands each centre pixel to the window generator and sorter, and writes medians out.
module median_scan_ctrl #(
  parameter int DIM_W  = 10,
  parameter int ADDR_W = 18,
  parameter int PIX_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [DIM_W-1:0]  cols,
  input  logic [DIM_W-1:0]  rows,
  output logic              center_pix_sig,
  output logic [DIM_W-1:0]  row_addr_sig,
  output logic [DIM_W-1:0]  column_addr_sig,
  input  logic              win_data_done_sig,
  output logic              med_start,
  input  logic              med_done,
  input  logic [PIX_W-1:0]  med_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [DIM_W-1:0]  DIM_ONE  = DIM_W'(1);
  localparam logic [DIM_W-1:0]  DIM_ZERO = DIM_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT_WIN = 3'd2,
    S_MSTART   = 3'd3,
    S_WAIT_MED = 3'd4,
    S_WRITE    = 3'd5,
    S_DONE     = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [DIM_W-1:0]    cols_q, cols_d;
  logic [DIM_W-1:0]    rows_q, rows_d;
  logic [DIM_W-1:0]    row_q, row_d;
  logic [DIM_W-1:0]    col_q, col_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [PIX_W-1:0]    data_q, data_d;
  logic                busy_q, busy_d;
  logic                center_q, center_d;
  logic                med_start_q, med_start_d;
  logic                wr_en_q, wr_en_d;
  logic                frame_done_q, frame_done_d;

  // Next-state logic; strobes are derived from the state being entered so
  // that every pulse output comes straight from a flop.
  always_comb begin
    state_d      = state_q;
    cols_d       = cols_q;
    rows_d       = rows_q;
    row_d        = row_q;
    col_d        = col_q;
    addr_d       = addr_q;
    data_d       = data_q;
    busy_d       = busy_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cols_d = cols;
          rows_d = rows;
          row_d  = DIM_ONE;
          col_d  = DIM_ONE;
          addr_d = '0;
          busy_d = 1'b1;
          if ((cols == DIM_ZERO) || (rows == DIM_ZERO)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_WIN;
      end
      S_WAIT_WIN: begin
        if (win_data_done_sig) begin
          state_d = S_MSTART;
        end else begin
          state_d = S_WAIT_WIN;
        end
      end
      S_MSTART: begin
        state_d = S_WAIT_MED;
      end
      S_WAIT_MED: begin
        if (med_done) begin
          data_d  = med_data;
          state_d = S_WRITE;
        end else begin
          state_d = S_WAIT_MED;
        end
      end
      S_WRITE: begin
        // Linear address tracks the raster position by increment only.
        addr_d = addr_q + ADDR_ONE;
        if (col_q < cols_q) begin
          col_d   = col_q + DIM_ONE;
          state_d = S_ISSUE;
        end else if (row_q < rows_q) begin
          col_d   = DIM_ONE;
          row_d   = row_q + DIM_ONE;
          state_d = S_ISSUE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    center_d     = (state_d == S_ISSUE);
    med_start_d  = (state_d == S_MSTART);
    wr_en_d      = (state_d == S_WRITE);
    frame_done_d = (state_d == S_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      cols_q       <= '0;
      rows_q       <= '0;
      row_q        <= DIM_ONE;
      col_q        <= DIM_ONE;
      addr_q       <= '0;
      data_q       <= '0;
      busy_q       <= 1'b0;
      center_q     <= 1'b0;
      med_start_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cols_q       <= cols_d;
      rows_q       <= rows_d;
      row_q        <= row_d;
      col_q        <= col_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
      center_q     <= center_d;
      med_start_q  <= med_start_d;
      wr_en_q      <= wr_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign center_pix_sig  = center_q;
  assign row_addr_sig    = row_q;
  assign column_addr_sig = col_q;
  assign med_start       = med_start_q;
  assign wr_en           = wr_en_q;
  assign wr_addr         = addr_q;
  assign wr_data         = data_q;
  assign busy            = busy_q;
  assign frame_done      = frame_done_q;

endmodule

// File: tb/tb_median_scan_ctrl.sv
// Bench for median_scan_ctrl: window/sorter responders with random latency,
// an event monitor, and a raster-order reference computed from rows/cols.
module tb_median_scan_ctrl;

  logic        CLK;
  logic        RST;
  logic        start;
  logic [9:0]  cols;
  logic [9:0]  rows;
  logic        center_pix_sig;
  logic [9:0]  row_addr_sig;
  logic [9:0]  column_addr_sig;
  logic        win_data_done_sig;
  logic        med_start;
  logic        med_done;
  logic [7:0]  med_data;
  logic        wr_en;
  logic [17:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        frame_done;

  int tests = 0;
  int fails = 0;

  // responder controls (written only by the main sequence)
  int dly_lo = 1;
  int dly_hi = 1;
  bit fixed_data = 1'b0;
  bit stray_req  = 1'b0;

  // observed events
  logic [31:0] cp_q[$];
  logic [17:0] wa_q[$];
  logic [7:0]  wd_q[$];
  logic [7:0]  med_sent[$];
  logic [7:0]  ram [0:63];
  int fd_cnt   = 0;
  int busy_cnt = 0;

  median_scan_ctrl #(.DIM_W(10), .ADDR_W(18), .PIX_W(8)) dut (
    .CLK(CLK), .RST(RST), .start(start), .cols(cols), .rows(rows),
    .center_pix_sig(center_pix_sig), .row_addr_sig(row_addr_sig),
    .column_addr_sig(column_addr_sig), .win_data_done_sig(win_data_done_sig),
    .med_start(med_start), .med_done(med_done), .med_data(med_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .frame_done(frame_done)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // window generator and median sorter stand-ins
  initial begin : responder
    int d;
    win_data_done_sig = 1'b0;
    med_done = 1'b0;
    med_data = 8'h00;
    @(negedge CLK);
    forever begin
      if (center_pix_sig === 1'b1) begin
        if (stray_req) begin
          @(negedge CLK);
          med_done = 1'b1;
          med_data = 8'h5A;
          @(negedge CLK);
          med_done = 1'b0;
          @(negedge CLK);
        end else begin
          d = $urandom_range(dly_hi, dly_lo);
          repeat (d) @(negedge CLK);
        end
        win_data_done_sig = 1'b1;
        @(negedge CLK);
        win_data_done_sig = 1'b0;
      end else if (med_start === 1'b1) begin
        d = $urandom_range(dly_hi, dly_lo);
        repeat (d) @(negedge CLK);
        if (fixed_data) med_data = 8'hA0 + 8'(med_sent.size());
        else            med_data = 8'($urandom);
        med_sent.push_back(med_data);
        med_done = 1'b1;
        @(negedge CLK);
        med_done = 1'b0;
      end else begin
        @(negedge CLK);
      end
    end
  end

  // event monitor, sampling away from the active edge
  initial begin : monitor
    forever begin
      @(negedge CLK);
      if (center_pix_sig === 1'b1) cp_q.push_back({12'd0, row_addr_sig, column_addr_sig});
      if (wr_en === 1'b1) begin
        wa_q.push_back(wr_addr);
        wd_q.push_back(wr_data);
        if (wr_addr < 18'd64) ram[wr_addr[5:0]] = wr_data;
      end
      if (frame_done === 1'b1) fd_cnt++;
      if (busy === 1'b1) busy_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    cp_q.delete();
    wa_q.delete();
    wd_q.delete();
    med_sent.delete();
    fd_cnt = 0;
    busy_cnt = 0;
  endtask

  task automatic launch(input int c, input int r);
    clear_obs();
    @(negedge CLK);
    cols  = 10'(c);
    rows  = 10'(r);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && fd_cnt == 0; i++) @(negedge CLK);
    repeat (4) @(negedge CLK);
  endtask

  // reference: raster order, address = (m-1)*c + (n-1), data = what the sorter returned
  task automatic check_frame(input string tag, input int c, input int r);
    int np;
    np = c * r;
    check($sformatf("%s_center_count", tag), cp_q.size(), np);
    check($sformatf("%s_write_count", tag), wa_q.size(), np);
    check($sformatf("%s_frame_done_count", tag), fd_cnt, 1);
    for (int k = 0; k < np; k++) begin
      int m, n;
      m = k / c + 1;
      n = k % c + 1;
      if (k < cp_q.size())
        check($sformatf("%s_rowcol_%0d", tag, k), cp_q[k], (m << 10) | n);
      if (k < wa_q.size()) begin
        check($sformatf("%s_addr_%0d", tag, k), {14'd0, wa_q[k]}, (m - 1) * c + (n - 1));
        if (k < med_sent.size())
          check($sformatf("%s_data_%0d", tag, k), {24'd0, wd_q[k]}, {24'd0, med_sent[k]});
      end
    end
  endtask

  initial begin : main
    int seen;
    int wr_before;
    RST   = 1'b1;
    start = 1'b0;
    cols  = 10'd0;
    rows  = 10'd0;
    repeat (3) @(negedge CLK);

    // reset values
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_center", {31'd0, center_pix_sig}, 32'd0);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_row", {22'd0, row_addr_sig}, 32'd1);
    check("rst_col", {22'd0, column_addr_sig}, 32'd1);
    check("rst_wr_addr", {14'd0, wr_addr}, 32'd0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // 3x3 with fixed sorter latency and A0+addr medians
    dly_lo = 2; dly_hi = 2; fixed_data = 1'b1;
    launch(3, 3);
    wait_done(2000);
    check_frame("f3x3", 3, 3);
    for (int k = 0; k < 9; k++) check($sformatf("ram_%0d", k), {24'd0, ram[k]}, 32'hA0 + k);
    check("f3x3_busy_after", {31'd0, busy}, 32'd0);

    // zero-width frame
    fixed_data = 1'b0;
    launch(0, 5);
    wait_done(50);
    check("zero_center_count", cp_q.size(), 0);
    check("zero_write_count", wa_q.size(), 0);
    check("zero_frame_done", fd_cnt, 1);
    check("zero_busy_cycles", busy_cnt, 1);

    // restart request and dimension changes mid-frame of 4x2
    dly_lo = 1; dly_hi = 3;
    launch(4, 2);
    repeat (12) @(negedge CLK);
    cols = 10'd7; rows = 10'd7; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_done(2000);
    check_frame("f4x2", 4, 2);

    // stray sorter pulses while waiting for each window
    stray_req = 1'b1;
    launch(3, 2);
    wait_done(2000);
    stray_req = 1'b0;
    check_frame("stray", 3, 2);

    // reset during WAIT_MED of pixel 5
    dly_lo = 3; dly_hi = 3; fixed_data = 1'b1;
    launch(3, 3);
    seen = 0;
    for (int i = 0; i < 500 && seen < 5; i++) begin
      @(negedge CLK);
      if (med_start === 1'b1) seen++;
    end
    check("rst_mid_reached_pixel5", seen, 5);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_mid_row", {22'd0, row_addr_sig}, 32'd1);
    check("rst_mid_col", {22'd0, column_addr_sig}, 32'd1);
    check("rst_mid_wr_addr", {14'd0, wr_addr}, 32'd0);
    wr_before = wa_q.size();
    check("rst_mid_writes_before", wr_before, 4);
    repeat (8) @(negedge CLK);
    check("rst_mid_no_more_writes", wa_q.size(), wr_before);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    dly_lo = 1; dly_hi = 2;
    launch(3, 3);
    wait_done(2000);
    check_frame("after_rst", 3, 3);

    // random frames
    fixed_data = 1'b0;
    dly_lo = 1; dly_hi = 3;
    for (int t = 0; t < 4; t++) begin
      int c, r;
      c = $urandom_range(5, 1);
      r = $urandom_range(4, 1);
      launch(c, r);
      wait_done(3000);
      check_frame($sformatf("rand%0d", t), c, r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
